// File: rtl/ifetch_queue.sv
// Instruction-fetch queue: sequential fetch to a 1-cycle synchronous imem, PC-tagged FIFO, redirect flush.
// Optional IFQ_BYPASS_EN lets a response reach decode in its arrival cycle when the queue is empty.
module ifetch_queue #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                     clk,
  input  logic                     rst,
  output logic                     imem_req,
  output logic [31:0]              imem_addr,
  input  logic [31:0]              imem_rdata,
  input  logic                     redirect_valid,
  input  logic [31:0]              redirect_pc,
  output logic                     instr_valid,
  output logic [31:0]              instr,
  output logic [31:0]              instr_pc,
  input  logic                     instr_ready,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam logic [PW+1:0] DEPTH_W = (PW+2)'(DEPTH);

  logic [31:0]   word_mem [DEPTH];
  logic [31:0]   pc_mem   [DEPTH];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [PW:0]   count_q;
  logic [31:0]   fetch_pc_q, req_pc_q;
  logic          inflight_q, inflight_epoch_q, epoch_q;
  logic [31:0]   last_instr_q, last_pc_q;

  logic [PW+1:0] used;
  logic          resp_ok, q_valid, push, pop;

  // Credits use registered occupancy only, so a same-cycle pop frees nothing until next cycle.
  assign used      = {1'b0, count_q} + (PW+2)'(inflight_q);
  assign imem_req  = !rst && !redirect_valid && (used < DEPTH_W);
  assign imem_addr = fetch_pc_q;
  assign count     = count_q;
  assign resp_ok   = inflight_q && (inflight_epoch_q == epoch_q) && !redirect_valid;

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    q_valid     = (count_q != '0);
    push        = resp_ok;
    instr_valid = q_valid;
    instr       = last_instr_q;
    instr_pc    = last_pc_q;
    if (q_valid) begin
      instr    = word_mem[rd_ptr_q];
      instr_pc = pc_mem[rd_ptr_q];
    end
`ifdef IFQ_BYPASS_EN
    else if (resp_ok) begin
      instr_valid = 1'b1;
      instr       = imem_rdata;
      instr_pc    = req_pc_q;
      push        = !instr_ready;
    end
`endif
    pop = q_valid && instr_ready;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc_q       <= RESET_PC;
      req_pc_q         <= '0;
      inflight_q       <= 1'b0;
      inflight_epoch_q <= 1'b0;
      epoch_q          <= 1'b0;
      wr_ptr_q         <= '0;
      rd_ptr_q         <= '0;
      count_q          <= '0;
      last_instr_q     <= '0;
      last_pc_q        <= '0;
    end else begin
      inflight_q <= imem_req;
      if (instr_valid) begin
        last_instr_q <= instr;
        last_pc_q    <= instr_pc;
      end
      if (redirect_valid) begin
        // Flipping the epoch marks anything still in flight as stale.
        epoch_q    <= ~epoch_q;
        fetch_pc_q <= redirect_pc & ~32'h3;
        wr_ptr_q   <= '0;
        rd_ptr_q   <= '0;
        count_q    <= '0;
      end else begin
        if (imem_req) begin
          fetch_pc_q       <= fetch_pc_q + 32'd4;
          req_pc_q         <= fetch_pc_q;
          inflight_epoch_q <= epoch_q;
        end
        if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
        if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
        case ({push, pop})
          2'b10:   count_q <= count_q + (PW+1)'(1);
          2'b01:   count_q <= count_q - (PW+1)'(1);
          default: count_q <= count_q;
        endcase
      end
    end
  end

  // NOTE: storage is not reset; occupancy and pointers alone decide which entries are meaningful.
  always_ff @(posedge clk) begin
    if (!rst && push) begin
      word_mem[wr_ptr_q] <= imem_rdata;
      pc_mem[wr_ptr_q]   <= req_pc_q;
    end
  end

endmodule

// File: tb/tb_ifetch_queue.sv
// Directed bench for ifetch_queue: reset, streaming, fill, redirect, wrap, back-to-back redirect, reset mid-stream.
module tb_ifetch_queue;

`ifdef IFQ_BYPASS_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 3;
`endif

  logic        clk = 1'b0;
  logic        rst, redirect_valid, instr_ready;
  logic [31:0] redirect_pc;
  logic        imem_req, instr_valid;
  logic [31:0] imem_addr, instr, instr_pc;
  logic [31:0] imem_rdata = '0;
  logic [2:0]  count;
  logic        w_imem_req, w_instr_valid;
  logic [31:0] w_imem_addr, w_instr, w_instr_pc;
  logic [31:0] w_imem_rdata = '0;
  logic [2:0]  w_count;

  int checks = 0;
  int failures = 0;

  ifetch_queue #(.DEPTH(4), .RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rst(rst), .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .instr_valid(instr_valid),
    .instr(instr), .instr_pc(instr_pc), .instr_ready(instr_ready), .count(count));

  ifetch_queue #(.DEPTH(4), .RESET_PC(32'hFFFF_FFF8)) dut_w (
    .clk(clk), .rst(rst), .imem_req(w_imem_req), .imem_addr(w_imem_addr), .imem_rdata(w_imem_rdata),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .instr_valid(w_instr_valid),
    .instr(w_instr), .instr_pc(w_instr_pc), .instr_ready(instr_ready), .count(w_count));

  always #5 clk = ~clk;

  // Instruction memories: word = addr ^ A5A50000, returned one cycle after the request.
  always @(posedge clk) if (imem_req)   imem_rdata   <= imem_addr ^ 32'hA5A5_0000;
  always @(posedge clk) if (w_imem_req) w_imem_rdata <= w_imem_addr ^ 32'hA5A5_0000;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Ends in the first cycle after reset with inputs applied and outputs settled.
  task automatic reset_dut();
    cyc(); rst = 1'b1;
    cyc();
    cyc(); rst = 1'b0;
    #1;
  endtask

  initial begin
    int reqs;
    logic [31:0] exp_pc;
    rst = 1'b1; redirect_valid = 1'b0; redirect_pc = '0; instr_ready = 1'b1;

    // Reset state
    repeat (3) cyc();
    #1;
    check("rst_req",   32'(imem_req), 32'd0);
    check("rst_valid", 32'(instr_valid), 32'd0);
    check("rst_count", 32'(count), 32'd0);
    check("rst_instr", instr, 32'd0);
    check("rst_pc",    instr_pc, 32'd0);

    // Streaming from reset; wrap instance runs alongside
    cyc(); rst = 1'b0; #1;
    check("s_req1",   32'(imem_req), 32'd1);
    check("s_addr1",  imem_addr, 32'd0);
    check("s_valid1", 32'(instr_valid), 32'd0);
    check("w_addr1",  w_imem_addr, 32'hFFFF_FFF8);
    for (int c = 2; c <= 9; c++) begin
      cyc(); #1;
      check("s_req",  32'(imem_req), 32'd1);
      check("s_addr", imem_addr, 32'(4 * (c - 1)));
      if (c >= LAT) begin
        exp_pc = 32'(4 * (c - LAT));
        check("s_valid", 32'(instr_valid), 32'd1);
        check("s_pc",    instr_pc, exp_pc);
        check("s_instr", instr, exp_pc ^ 32'hA5A5_0000);
        if (c < LAT + 4) begin
          exp_pc = 32'hFFFF_FFF8 + 32'(4 * (c - LAT));
          check("w_pc",    w_instr_pc, exp_pc);
          check("w_instr", w_instr, exp_pc ^ 32'hA5A5_0000);
        end
      end else begin
        check("s_valid0", 32'(instr_valid), 32'd0);
      end
    end

    // Fill with decode stalled
    instr_ready = 1'b0;
    reset_dut();
    reqs = 0;
    for (int i = 0; i < 10; i++) begin
      if (i > 0) begin cyc(); #1; end
      if (imem_req) begin
        check("f_addr", imem_addr, 32'(4 * reqs));
        reqs++;
      end
      if (count == 3'd4) check("f_full_noreq", 32'(imem_req), 32'd0);
    end
    check("f_reqs",  32'(reqs), 32'd4);
    check("f_count", 32'(count), 32'd4);
    check("f_req0",  32'(imem_req), 32'd0);
    check("f_head",  instr_pc, 32'd0);
    cyc(); instr_ready = 1'b1; #1;
    for (int k = 0; k < 5; k++) begin
      if (k > 0) begin cyc(); #1; end
      check("d_valid", 32'(instr_valid), 32'd1);
      check("d_pc",    instr_pc, 32'(4 * k));
      if (k == 0) check("d_req_m", 32'(imem_req), 32'd0);
      if (k == 1) begin
        check("d_req_resume",  32'(imem_req), 32'd1);
        check("d_addr_resume", imem_addr, 32'h10);
      end
    end

    // Redirect with two entries queued and one in flight
    instr_ready = 1'b0;
    reset_dut();
    cyc(); #1;
    cyc(); #1;
    cyc(); redirect_valid = 1'b1; redirect_pc = 32'h0000_0103; #1;
    check("r_count_pre", 32'(count), 32'd2);
    check("r_req_sup",   32'(imem_req), 32'd0);
    cyc(); redirect_valid = 1'b0; instr_ready = 1'b1; #1;
    check("r_count0", 32'(count), 32'd0);
    check("r_valid0", 32'(instr_valid), 32'd0);
    check("r_req",    32'(imem_req), 32'd1);
    check("r_addr",   imem_addr, 32'h100);
    for (int c = 2; c <= 5; c++) begin
      cyc(); #1;
      check("r_addr_n", imem_addr, 32'h100 + 32'(4 * (c - 1)));
      if (c >= LAT) begin
        exp_pc = 32'h100 + 32'(4 * (c - LAT));
        check("r_valid", 32'(instr_valid), 32'd1);
        check("r_pc",    instr_pc, exp_pc);
        check("r_instr", instr, exp_pc ^ 32'hA5A5_0000);
      end else begin
        check("r_valid_lat", 32'(instr_valid), 32'd0);
      end
    end

    // Pop + redirect together, then a second redirect to 0x200
    instr_ready = 1'b0;
    reset_dut();
    cyc(); #1;
    cyc(); #1;
    cyc(); redirect_valid = 1'b1; redirect_pc = 32'h300; instr_ready = 1'b1; #1;
    check("p_valid", 32'(instr_valid), 32'd1);
    check("p_pc",    instr_pc, 32'd0);
    cyc(); redirect_pc = 32'h200; #1;
    check("p_req_sup2", 32'(imem_req), 32'd0);
    check("p_count0",   32'(count), 32'd0);
    check("p_valid0",   32'(instr_valid), 32'd0);
    check("p_hold_pc",  instr_pc, 32'd0);
    cyc(); redirect_valid = 1'b0; #1;
    check("p_req",   32'(imem_req), 32'd1);
    check("p_addr",  imem_addr, 32'h200);
    check("p_empty", 32'(instr_valid), 32'd0);
    for (int c = 2; c <= 5; c++) begin
      cyc(); #1;
      if (c >= LAT) begin
        check("p_valid_n", 32'(instr_valid), 32'd1);
        check("p_pc_n",    instr_pc, 32'h200 + 32'(4 * (c - LAT)));
      end else begin
        check("p_valid_lat", 32'(instr_valid), 32'd0);
      end
    end

    // Reset together with a redirect mid-stream
    cyc(); rst = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h400; #1;
    check("x_req", 32'(imem_req), 32'd0);
    cyc(); rst = 1'b0; redirect_valid = 1'b0; #1;
    check("x_count", 32'(count), 32'd0);
    check("x_valid", 32'(instr_valid), 32'd0);
    check("x_instr", instr, 32'd0);
    check("x_pc",    instr_pc, 32'd0);
    check("x_req1",  32'(imem_req), 32'd1);
    check("x_addr",  imem_addr, 32'd0);
    check("x_w_addr", w_imem_addr, 32'hFFFF_FFF8);
    cyc(); #1;
    check("x_addr2", imem_addr, 32'd4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
